fir_stream_engine: RTL and testbench
====================================

Name: fir_stream_engine

Overview:
- Parametrised N-tap FIR engine: AXI-Lite configuration/status, AXI-Stream sample input and output, external single-port tap and data BRAMs.
- Successor to the fixed 11-tap FIR. Adds runtime tap count, data-RAM clear on start, a complete ap_done/ap_idle protocol, sm_tlast generation and a registered AXI-Lite read path.
- Sits between the CPU-side AXI-Lite bus and the DMA-side AXI-Stream pair.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width (byte addresses).
- pDATA_WIDTH, 32, sample, coefficient and accumulator width.
- NUM_TAPS, 32, maximum tap count; also the data-RAM circular-buffer depth.

Ports:
- axis_clk  in  1  single clock.
- axis_rst  in  1  synchronous active-high reset.
- awvalid, awaddr[pADDR_WIDTH], wvalid, wdata[pDATA_WIDTH]  in  AXI-Lite write; awready, wready  out  1.
- arvalid, araddr[pADDR_WIDTH], rready  in  AXI-Lite read; arready, rvalid  out  1; rdata  out  pDATA_WIDTH.
- ss_tvalid, ss_tdata[pDATA_WIDTH], ss_tlast  in  stream in; ss_tready  out  1.
- sm_tready  in  1; sm_tvalid, sm_tlast  out  1; sm_tdata  out  pDATA_WIDTH  stream out.
- tap_WE[4], tap_EN, tap_Di, tap_A  out; tap_Do  in  tap BRAM, 1-cycle read latency.
- data_WE[4], data_EN, data_Di, data_A  out; data_Do  in  data BRAM, 1-cycle read latency.

Behaviour:
Interface and reset:
- One clock (axis_clk); reset axis_rst is synchronous, active-high.
- Reset values: all ready/valid outputs 0, rdata 0, sm_tdata 0, BRAM EN/WE 0, ap_start 0, ap_done 0, ap_idle 1, data_length 0, tap_num NUM_TAPS.
- Reset mid-operation aborts the FSM to IDLE; BRAM contents are not touched.

Register map (word-aligned):
- 0x00 ctrl: bit0 ap_start (write 1 sets, self-clears on IDLE->CLEAR); bit1 ap_done (RO, cleared by the read of 0x00 that returns it); bit2 ap_idle (RO).
- 0x10 data_length.
- 0x14 tap_num: values 0 or >NUM_TAPS clamp to NUM_TAPS.
- 0x40 + 4*i: tap i, for i < NUM_TAPS.

AXI-Lite write:
- awready = wready = awvalid & wvalid & no tap-BRAM conflict.
- Accepts one write per cycle.
- Writes to 0x10/0x14/taps while ap_idle=0 are acknowledged and dropped.
- ap_start write while ap_idle=0 is ignored.

AXI-Lite read:
- arready=1 when no read is pending.
- rvalid is registered 1 cycle after the address is accepted (2 cycles for tap reads); rvalid/rdata hold until rready.
- Tap reads while ap_idle=0 return 0xFFFFFFFF.
- Unmapped addresses return 0.

FSM (IDLE, CLEAR, WAIT_IN, MAC, OUT, DONE):
- IDLE: ap_idle=1. ap_start -> CLEAR, ap_idle<=0.
- CLEAR: writes 0 to data RAM words 0..NUM_TAPS-1, one per cycle, taking NUM_TAPS cycles; then WAIT_IN.
- WAIT_IN: ss_tready=1. On handshake, writes the sample at head pointer p, latches ss_tlast, -> MAC.
- MAC: reads tap i and x at (p - i) mod NUM_TAPS, for i = 0..tap_num-1.
  - Products are truncated to pDATA_WIDTH two's complement; accumulator wraps.
  - MAC lasts tap_num+1 cycles (pipelined, 1-cycle BRAM latency).
- OUT: sm_tvalid=1, sm_tdata=acc held until sm_tready.
  - sm_tlast=1 when the output count == data_length, or the latched ss_tlast is set.
  - On handshake: head pointer p increments with wrap at NUM_TAPS-1 -> 0; -> DONE if tlast, else WAIT_IN.
- DONE: ap_done<=1, ap_idle<=1, -> IDLE.
- Simultaneous ap_done read and DONE set: set wins.

Datapath:
- y[n] = sum over i < tap_num of h[i]*x[n-i], with x[k<0] = 0 (guaranteed by CLEAR).
- Throughput: one sample per tap_num+3 cycles when both streams are always ready.

Optional Feature:
- FIR_SAT_EN defined: products are computed at full 2*pDATA_WIDTH width, the accumulator is pDATA_WIDTH+8 bits, and the output saturates to the signed pDATA_WIDTH max/min (0x7FFFFFFF / 0x80000000 at width 32).
- Undefined: truncating, wrapping arithmetic as specified above.

Test Plan:
1. Taps 0..10 (11 taps), tap_num=11, data_length=600, x[n]=n -> y matches golden model for all 600 outputs; sm_tlast only on output 600; ap_done=1 then ap_idle=1; reading 0x00 returns 0x6, a second read returns 0x4.
2. Run twice back-to-back with different data -> the second run's first output = h[0]*x[0] only (CLEAR verified; no stale samples).
3. tap_num=0 write -> reads back NUM_TAPS. tap_num=3 with h={1,1,1}, x={1,2,3,4} -> y={1,3,6,9}.
4. sm_tready held low 20 cycles mid-stream -> sm_tvalid/sm_tdata stable; ss_tready stays 0; no sample lost.
5. Tap read at 0x44 while ap_idle=0 -> 0xFFFFFFFF; tap write during run -> tap unchanged after DONE.
6. FIR_SAT_EN: h[0]=0x7FFFFFFF, x=2 -> output 0x7FFFFFFF. Without the macro -> 0xFFFFFFFE.

Source files
------------

// File: rtl/fir_stream_engine.sv
// Streaming N-tap FIR: AXI-Lite config/status, AXI-Stream in/out, external tap and data BRAMs.
// Define FIR_SAT_EN for full-width products, a widened accumulator and a saturating output.

module fir_stream_engine #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int NUM_TAPS    = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   awready,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    input  logic                   rready,
    output logic                   rvalid,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic [3:0]             data_WE,
    output logic                   data_EN,
    output logic [pDATA_WIDTH-1:0] data_Di,
    output logic [pADDR_WIDTH-1:0] data_A,
    input  logic [pDATA_WIDTH-1:0] data_Do
);

    localparam int CW = $clog2(NUM_TAPS + 1);
`ifdef FIR_SAT_EN
    localparam int AW = pDATA_WIDTH + 8;
    localparam logic [AW-1:0] SAT_MAX = AW'({1'b0, {(pDATA_WIDTH-1){1'b1}}});
    localparam logic [AW-1:0] SAT_MIN = ~SAT_MAX;
`else
    localparam int AW = pDATA_WIDTH;
`endif
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAPN = pADDR_WIDTH'('h14);
    localparam logic [pADDR_WIDTH-1:0] TAP_LO    = pADDR_WIDTH'('h40);
    localparam logic [pADDR_WIDTH-1:0] TAP_HI    = pADDR_WIDTH'('h40 + 4 * NUM_TAPS);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          tapNum_q, macCnt_q, clrCnt_q, ptr_q, dataIdx, tapNumWr;
    logic [pDATA_WIDTH-1:0] dataLength_q, outCnt_q, rdata_q, rdMux, result;
    logic [AW-1:0]          acc_q, product;
    logic                   apStart_q, apDone_q, apIdle_q, lastIn_q;
    logic                   rdEn_q, rdPend_q, rdBlocked_q, rvalid_q;
    logic                   awTap, arTap, arFire, wrFire, tapRdGo, tapWrGo, macIssue, lastOut;

    assign awTap    = (awaddr >= TAP_LO) && (awaddr < TAP_HI);
    assign arTap    = (araddr >= TAP_LO) && (araddr < TAP_HI);
    assign arready  = rdEn_q && !rdPend_q && !rvalid_q;
    assign arFire   = arvalid && arready;
    assign tapRdGo  = arFire && arTap && apIdle_q;
    // A tap write yields the single BRAM port to a tap read accepted in the same cycle.
    assign wrFire   = awvalid && wvalid && !(awTap && apIdle_q && tapRdGo);
    assign tapWrGo  = wrFire && awTap && apIdle_q;
    assign awready  = wrFire;
    assign wready   = wrFire;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign macIssue = (state_q == S_MAC) && (macCnt_q < tapNum_q);
    assign dataIdx  = (ptr_q >= macCnt_q) ? ptr_q - macCnt_q : ptr_q + CW'(NUM_TAPS) - macCnt_q;
    assign lastOut  = lastIn_q || (outCnt_q + pDATA_WIDTH'(1) == dataLength_q);
    assign tapNumWr = (wdata == '0 || wdata > pDATA_WIDTH'(NUM_TAPS)) ? CW'(NUM_TAPS) : wdata[CW-1:0];

`ifdef FIR_SAT_EN
    logic signed [2*pDATA_WIDTH-1:0] prodFull;
    assign prodFull = $signed(tap_Do) * $signed(data_Do);
    assign product  = prodFull[AW-1:0];

    always_comb begin
        result = acc_q[pDATA_WIDTH-1:0];
        if ($signed(acc_q) > $signed(SAT_MAX)) result = SAT_MAX[pDATA_WIDTH-1:0];
        else if ($signed(acc_q) < $signed(SAT_MIN)) result = SAT_MIN[pDATA_WIDTH-1:0];
    end
`else
    assign product = tap_Do * data_Do;
    assign result  = acc_q;
`endif

    always_comb begin
        rdMux = '0;
        case (araddr)
            ADDR_CTRL: rdMux = pDATA_WIDTH'({apIdle_q, apDone_q, apStart_q});
            ADDR_LEN:  rdMux = dataLength_q;
            ADDR_TAPN: rdMux = pDATA_WIDTH'(tapNum_q);
            default:   rdMux = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tdata  = '0;
        sm_tlast  = 1'b0;
        tap_EN    = 1'b0;
        tap_WE    = 4'h0;
        tap_A     = '0;
        tap_Di    = '0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        data_Di   = '0;
        case (state_q)
            S_IDLE: if (apStart_q) state_d = S_CLEAR;
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = pADDR_WIDTH'({clrCnt_q, 2'b00});
                if (clrCnt_q == CW'(NUM_TAPS - 1)) state_d = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                ss_tready = 1'b1;
                if (ss_tvalid) begin
                    data_EN = 1'b1;
                    data_WE = 4'hF;
                    data_A  = pADDR_WIDTH'({ptr_q, 2'b00});
                    data_Di = ss_tdata;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (macIssue) begin
                    tap_EN  = 1'b1;
                    tap_A   = pADDR_WIDTH'({macCnt_q, 2'b00});
                    data_EN = 1'b1;
                    data_A  = pADDR_WIDTH'({dataIdx, 2'b00});
                end
                if (macCnt_q == tapNum_q) state_d = S_OUT;
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                sm_tdata  = result;
                sm_tlast  = lastOut;
                if (sm_tready) state_d = lastOut ? S_DONE : S_WAIT_IN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (tapWrGo) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = awaddr - TAP_LO;
            tap_Di = wdata;
        end else if (tapRdGo) begin
            tap_EN = 1'b1;
            tap_A  = araddr - TAP_LO;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            tapNum_q     <= CW'(NUM_TAPS);
            dataLength_q <= '0;
            apStart_q    <= 1'b0;
            apDone_q     <= 1'b0;
            apIdle_q     <= 1'b1;
            lastIn_q     <= 1'b0;
            macCnt_q     <= '0;
            clrCnt_q     <= '0;
            ptr_q        <= '0;
            outCnt_q     <= '0;
            acc_q        <= '0;
            rdEn_q       <= 1'b0;
            rdPend_q     <= 1'b0;
            rdBlocked_q  <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            rdEn_q <= 1'b1;
            if (wrFire && apIdle_q) begin
                if (awaddr == ADDR_CTRL && wdata[0]) apStart_q <= 1'b1;
                if (awaddr == ADDR_LEN)  dataLength_q <= wdata;
                if (awaddr == ADDR_TAPN) tapNum_q <= tapNumWr;
            end
            case (state_q)
                S_IDLE: if (apStart_q) begin
                    apStart_q <= 1'b0;
                    apIdle_q  <= 1'b0;
                    clrCnt_q  <= '0;
                    ptr_q     <= '0;
                    outCnt_q  <= '0;
                end
                S_CLEAR: clrCnt_q <= clrCnt_q + CW'(1);
                S_WAIT_IN: if (ss_tvalid) begin
                    lastIn_q <= ss_tlast;
                    macCnt_q <= '0;
                    acc_q    <= '0;
                end
                // Cycle k accumulates the tap/sample pair whose reads were issued in cycle k-1.
                S_MAC: begin
                    macCnt_q <= macCnt_q + CW'(1);
                    if (macCnt_q != '0) acc_q <= acc_q + product;
                end
                S_OUT: if (sm_tready) begin
                    ptr_q    <= (ptr_q == CW'(NUM_TAPS - 1)) ? '0 : ptr_q + CW'(1);
                    outCnt_q <= outCnt_q + pDATA_WIDTH'(1);
                end
                default: ;
            endcase
            if (arFire && araddr == ADDR_CTRL) apDone_q <= 1'b0;
            if (state_q == S_DONE) begin
                apDone_q <= 1'b1;
                apIdle_q <= 1'b1;
            end
            // Tap reads wait one extra cycle for the BRAM; a busy engine answers all-ones instead.
            if (rvalid_q && rready) rvalid_q <= 1'b0;
            if (rdPend_q) begin
                rdPend_q <= 1'b0;
                rvalid_q <= 1'b1;
                rdata_q  <= rdBlocked_q ? '1 : tap_Do;
            end else if (arFire) begin
                if (arTap) begin
                    rdPend_q    <= 1'b1;
                    rdBlocked_q <= !apIdle_q;
                end else begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= rdMux;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_stream_engine.sv
// Self-checking bench for fir_stream_engine: directed jobs with randomized data against a convolution model.
// Honours FIR_SAT_EN in its reference model.

module tb_fir_stream_engine;

    localparam int NT = 32;

    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, ss_tdata = '0;
    logic        ss_tvalid = 1'b0, ss_tlast = 1'b0, sm_tready = 1'b0;
    logic        awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast;
    logic [31:0] rdata, sm_tdata;
    logic [3:0]  tap_WE, data_WE;
    logic        tap_EN, data_EN;
    logic [31:0] tap_Di, data_Di, tap_Do, data_Do;
    logic [11:0] tap_A, data_A;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] hArr [NT];
    logic [31:0] xArr [700];
    int          tapNumModel;
    logic [31:0] dataLenModel;
    logic [31:0] tapMem [NT];
    logic [31:0] dataMem [NT];

    always #5 axis_clk = ~axis_clk;

    fir_stream_engine #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .NUM_TAPS(NT)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rready(rready), .rvalid(rvalid), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tready(sm_tready), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
    );

    // Single-port BRAMs with one-cycle registered read.
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            for (int b = 0; b < 4; b++)
                if (tap_WE[b]) tapMem[tap_A[6:2]][b*8 +: 8] <= tap_Di[b*8 +: 8];
            tap_Do <= tapMem[tap_A[6:2]];
        end
        if (data_EN) begin
            for (int b = 0; b < 4; b++)
                if (data_WE[b]) dataMem[data_A[6:2]][b*8 +: 8] <= data_Di[b*8 +: 8];
            data_Do <= dataMem[data_A[6:2]];
        end
    end

    // Stale garbage in the data RAM makes a missing clear visible.
    initial begin
        for (int i = 0; i < NT; i++) dataMem[i] = $urandom;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelY(input int n);
`ifdef FIR_SAT_EN
        logic signed [71:0] s = '0;
        for (int i = 0; i < tapNumModel; i++)
            if (n - i >= 0) s += 72'($signed(hArr[i])) * 72'($signed(xArr[n-i]));
        if (s > 72'sh7FFFFFFF) return 32'h7FFFFFFF;
        if (s < -72'sh80000000) return 32'h80000000;
        return s[31:0];
`else
        logic [31:0] s = '0;
        for (int i = 0; i < tapNumModel; i++)
            if (n - i >= 0) s += hArr[i] * xArr[n-i];
        return s;
`endif
    endfunction

    function automatic logic [31:0] randVal();
`ifdef FIR_SAT_EN
        logic signed [15:0] t = 16'($urandom);
        return 32'(t);
`else
        return $urandom;
`endif
    endfunction

    task automatic axiWrite(input logic [11:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge axis_clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
        #1;
        while (!awready && n < 50) begin @(negedge axis_clk); #1; n++; end
        checkOutput("awready", {31'b0, awready}, 32'd1);
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axiRead(input logic [11:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge axis_clk);
        arvalid = 1'b1; araddr = a; rready = 1'b0;
        #1;
        while (!arready && n < 50) begin @(negedge axis_clk); #1; n++; end
        checkOutput("arready", {31'b0, arready}, 32'd1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        n = 0;
        @(negedge axis_clk);
        while (!rvalid && n < 50) begin @(negedge axis_clk); n++; end
        checkOutput("rvalid", {31'b0, rvalid}, 32'd1);
        d = rdata;
        rready = 1'b1;
        @(posedge axis_clk); #1;
        rready = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axiRead(a, d);
        checkOutput(tag, d, exp);
    endtask

    task automatic setupJob(input int taps, input logic [31:0] len);
        for (int i = 0; i < taps; i++) axiWrite(12'(32'h40 + 4 * i), hArr[i]);
        axiWrite(12'h14, 32'(taps));
        axiWrite(12'h10, len);
        tapNumModel  = taps;
        dataLenModel = len;
        axiWrite(12'h00, 32'd1);
    endtask

    task automatic busyProbe();
        readCheck("busy_tap_read", 12'h44, 32'hFFFFFFFF);
        axiWrite(12'h44, 32'h12345678);
        axiWrite(12'h10, 32'd7);
        readCheck("busy_ctrl", 12'h00, 32'h0);
    endtask

    task automatic applyStimulus(input int nSamp, input bit useInLast, input int stallAt, input int probeAt);
        int          n;
        logic [31:0] expY;
        logic        expLast;
        for (int k = 0; k < nSamp; k++) begin
            if (k == probeAt) busyProbe();
            @(negedge axis_clk);
            ss_tvalid = 1'b1; ss_tdata = xArr[k]; ss_tlast = useInLast && (k == nSamp - 1);
            n = 0; #1;
            while (!ss_tready && n < 100) begin @(negedge axis_clk); #1; n++; end
            checkOutput("ss_tready", {31'b0, ss_tready}, 32'd1);
            @(posedge axis_clk); #1;
            ss_tvalid = 1'b0; ss_tlast = 1'b0;
            n = 0;
            @(negedge axis_clk);
            while (!sm_tvalid && n < 100) begin @(negedge axis_clk); n++; end
            expY    = modelY(k);
            expLast = (32'(k + 1) == dataLenModel) || (useInLast && k == nSamp - 1);
            checkOutput("sm_tdata", sm_tdata, expY);
            checkOutput("sm_tlast", {31'b0, sm_tlast}, {31'b0, expLast});
            if (k == stallAt) begin
                repeat (20) begin
                    @(negedge axis_clk);
                    checkOutput("stall_tvalid", {31'b0, sm_tvalid}, 32'd1);
                    checkOutput("stall_tdata", sm_tdata, expY);
                    checkOutput("stall_ss_tready", {31'b0, ss_tready}, 32'd0);
                end
            end
            @(negedge axis_clk);
            sm_tready = 1'b1;
            @(posedge axis_clk); #1;
            sm_tready = 1'b0;
        end
    endtask

    task automatic finishJob();
        repeat (4) @(negedge axis_clk);
        readCheck("ctrl_done", 12'h00, 32'h6);
        readCheck("ctrl_after", 12'h00, 32'h4);
    endtask

    initial begin
        $display("[TB] starting fir_stream_engine bench");
        repeat (3) @(negedge axis_clk);
        checkOutput("rst_ss_tready", {31'b0, ss_tready}, 32'd0);
        checkOutput("rst_sm_tvalid", {31'b0, sm_tvalid}, 32'd0);
        checkOutput("rst_sm_tdata", sm_tdata, 32'd0);
        checkOutput("rst_rvalid", {31'b0, rvalid}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_arready", {31'b0, arready}, 32'd0);
        checkOutput("rst_awready", {31'b0, awready}, 32'd0);
        checkOutput("rst_bram_en", {30'b0, tap_EN, data_EN}, 32'd0);
        checkOutput("rst_bram_we", {24'b0, tap_WE, data_WE}, 32'd0);
        axis_rst = 1'b0;
        readCheck("rst_ctrl", 12'h00, 32'h4);
        readCheck("rst_len", 12'h10, 32'd0);
        readCheck("rst_tapnum", 12'h14, 32'(NT));
        readCheck("unmapped", 12'h20, 32'd0);

        $display("[TB] job 1: 11 taps, ramp input, 600 outputs");
        for (int i = 0; i < 11; i++) hArr[i] = 32'(i);
        for (int i = 0; i < 600; i++) xArr[i] = 32'(i);
        setupJob(11, 32'd600);
        applyStimulus(600, 1'b0, 300, 150);
        finishJob();
        readCheck("tap1_kept", 12'h44, 32'd1);
        readCheck("len_kept", 12'h10, 32'd600);

        $display("[TB] job 2: back-to-back run, random data, input tlast");
        for (int i = 0; i < 5; i++) hArr[i] = randVal();
        for (int i = 0; i < 12; i++) xArr[i] = randVal();
        setupJob(5, 32'd0);
        applyStimulus(12, 1'b1, -1, -1);
        finishJob();

        $display("[TB] job 3: tap_num clamping and 3-tap sum");
        axiWrite(12'h14, 32'd0);
        readCheck("tapnum_zero", 12'h14, 32'(NT));
        axiWrite(12'h14, 32'd33);
        readCheck("tapnum_big", 12'h14, 32'(NT));
        for (int i = 0; i < 3; i++) hArr[i] = 32'd1;
        for (int i = 0; i < 4; i++) xArr[i] = 32'(i + 1);
        setupJob(3, 32'd4);
        applyStimulus(4, 1'b0, -1, -1);
        finishJob();

        $display("[TB] job 4: full 32 taps, buffer wraparound");
        for (int i = 0; i < NT; i++) hArr[i] = randVal();
        for (int i = 0; i < 45; i++) xArr[i] = randVal();
        setupJob(NT, 32'd45);
        applyStimulus(45, 1'b0, -1, -1);
        finishJob();

        $display("[TB] job 5: overflow behaviour");
        hArr[0] = 32'h7FFFFFFF;
        xArr[0] = 32'd2;
        setupJob(1, 32'd1);
        applyStimulus(1, 1'b0, -1, -1);
        finishJob();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
